// File: rtl/branch_pkg.sv
// Shared definitions for the decode-stage branch unit: branch mode encodings,
// predictor reset state and the 2-bit saturating counter helpers.
package branch_pkg;

    typedef enum logic [2:0] {
        BR_EQ   = 3'd0,
        BR_NE   = 3'd1,
        BR_LTZ  = 3'd2,
        BR_GEZ  = 3'd3,
        BR_GTZ  = 3'd4,
        BR_LEZ  = 3'd5,
        BR_JREG = 3'd6,
        BR_JVAL = 3'd7
    } br_op_e;

    // Weakly not-taken: one taken outcome flips the prediction.
    localparam logic [1:0] BHT_RESET = 2'b01;

    // Conditional modes train the predictor; jumps are always taken and never do.
    function automatic logic br_is_cond(input logic [2:0] op);
        return (op <= 3'(BR_LEZ));
    endfunction

    function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic up);
        logic [1:0] nxt;
        nxt = cur;
        if (up) begin
            if (cur != 2'b11) nxt = cur + 2'b01;
        end else begin
            if (cur != 2'b00) nxt = cur - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluation on two's complement decode operands.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       BrOpD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    output logic             taken
);

    logic rd1_neg;
    logic rd1_zero;
    logic ops_eq;

    assign rd1_neg  = RD1D[WIDTH-1];
    assign rd1_zero = (RD1D == '0);
    assign ops_eq   = (RD1D == RD2D);

    always_comb begin
        taken = 1'b0;
        case (br_op_e'(BrOpD))
            BR_EQ:   taken = ops_eq;
            BR_NE:   taken = !ops_eq;
            BR_LTZ:  taken = rd1_neg;
            BR_GEZ:  taken = !rd1_neg;
            BR_GTZ:  taken = !rd1_neg && !rd1_zero;
            BR_LEZ:  taken = rd1_neg || rd1_zero;
            BR_JREG: taken = 1'b1;
            BR_JVAL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Decode-stage branch resolution with a bimodal 2-bit predictor table,
// prediction pipeline register and branch / mispredict performance counters.
module branch_unit
    import branch_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 64,   // power of two, >= 4
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] PCF,
    input  logic [WIDTH-1:0] PCD,
    input  logic             BranchD,
    input  logic [2:0]       BrOpD,
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic             StallD,
    input  logic             FlushD,
    output logic             PredTakenF,
    output logic             PCSrcD,
    output logic             MispredictD,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] MispredCnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       bht_q [BHT_DEPTH];
    logic [1:0]       bht_upd;
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_d;

    logic             pred_taken_d_q;
    logic             pred_taken_d_d;
    logic [CNT_W-1:0] branch_cnt_q;
    logic [CNT_W-1:0] branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q;
    logic [CNT_W-1:0] mispred_cnt_d;

    logic             taken;
    logic             bht_we;

    // Word-aligned PCs: the two low bits never select an entry.
    assign idx_f = PCF[IDX_W+1:2];
    assign idx_d = PCD[IDX_W+1:2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{PCF[WIDTH-1:IDX_W+2], PCF[1:0],
                              PCD[WIDTH-1:IDX_W+2], PCD[1:0]};

    branch_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .BrOpD (BrOpD),
        .RD1D  (RD1D),
        .RD2D  (RD2D),
        .taken (taken)
    );

    // Read returns the registered value, so a same-cycle update is not bypassed.
    assign PredTakenF = bht_q[idx_f][1];

    assign bht_we      = BranchD && br_is_cond(BrOpD) && !StallD && !FlushD;
    assign PCSrcD      = BranchD && taken;
    assign MispredictD = bht_we && (taken != pred_taken_d_q);
    assign bht_upd     = bht_next(bht_q[idx_d], taken);

    always_comb begin
        pred_taken_d_d = PredTakenF;
        branch_cnt_d   = branch_cnt_q;
        mispred_cnt_d  = mispred_cnt_q;

        if (FlushD) begin
            pred_taken_d_d = 1'b0;
        end else if (StallD) begin
            pred_taken_d_d = pred_taken_d_q;
        end

        if (bht_we) begin
            branch_cnt_d = branch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (MispredictD) begin
            mispred_cnt_d = mispred_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_taken_d_q <= 1'b0;
            branch_cnt_q   <= '0;
            mispred_cnt_q  <= '0;
        end else begin
            pred_taken_d_q <= pred_taken_d_d;
            branch_cnt_q   <= branch_cnt_d;
            mispred_cnt_q  <= mispred_cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht_q[i] <= BHT_RESET;
            end
        end else if (bht_we) begin
            bht_q[idx_d] <= bht_upd;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: prediction, resolution, training, stall/flush
// handling, counters and asynchronous reset.
module tb_branch_unit;
    import branch_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PCF = 32'h40;
    logic [31:0] PCD = '0;
    logic        BranchD = 1'b0;
    logic [2:0]  BrOpD = '0;
    logic [31:0] RD1D = '0;
    logic [31:0] RD2D = '0;
    logic        StallD = 1'b0;
    logic        FlushD = 1'b0;
    logic        PredTakenF;
    logic        PCSrcD;
    logic        MispredictD;
    logic [31:0] BranchCnt;
    logic [31:0] MispredCnt;

    int n_checks = 0;
    int n_errors = 0;

    branch_unit #(.WIDTH(32), .BHT_DEPTH(64), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCF         (PCF),
        .PCD         (PCD),
        .BranchD     (BranchD),
        .BrOpD       (BrOpD),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .StallD      (StallD),
        .FlushD      (FlushD),
        .PredTakenF  (PredTakenF),
        .PCSrcD      (PCSrcD),
        .MispredictD (MispredictD),
        .BranchCnt   (BranchCnt),
        .MispredCnt  (MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_br(input logic [2:0] op, input logic [31:0] pcd,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic stall, input logic flush);
        BranchD = 1'b1;
        BrOpD   = op;
        PCD     = pcd;
        RD1D    = rd1;
        RD2D    = rd2;
        StallD  = stall;
        FlushD  = flush;
    endtask

    task automatic idle();
        BranchD = 1'b0;
        BrOpD   = '0;
        StallD  = 1'b0;
        FlushD  = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        exp;
    } cmp_vec_t;

    cmp_vec_t cvec [6];

    initial begin
        cvec[0] = '{3'd2, 32'h8000_0000, 32'h0, 1'b1};
        cvec[1] = '{3'd4, 32'h0,         32'h0, 1'b0};
        cvec[2] = '{3'd5, 32'h0,         32'h0, 1'b1};
        cvec[3] = '{3'd3, 32'hFFFF_FFFF, 32'h0, 1'b0};
        cvec[4] = '{3'd1, 32'd5,         32'd6, 1'b1};
        cvec[5] = '{3'd0, 32'd5,         32'd6, 1'b0};

        // reset held
        repeat (2) step();
        check_val("rst_pred_d", dut.pred_taken_d_q, 0);
        check_val("rst_bht16", dut.bht_q[16], 2'b01);
        check_val("rst_bcnt", BranchCnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        check_val("pred_f_0x40", PredTakenF, 0);
        check_val("bcnt_init", BranchCnt, 0);
        check_val("mcnt_init", MispredCnt, 0);

        // three taken EQ branches, idle cycle between to refresh the prediction
        for (int k = 0; k < 3; k++) begin
            drive_br(3'd0, 32'h40, 32'd5, 32'd5, 1'b0, 1'b0);
            #1;
            check_val($sformatf("eq%0d_pcsrc", k), PCSrcD, 1);
            check_val($sformatf("eq%0d_misp", k), MispredictD, (k == 0) ? 1 : 0);
            step();
            idle();
            #1;
            check_val($sformatf("eq%0d_bht16", k), dut.bht_q[16], (k == 0) ? 2 : 3);
            check_val($sformatf("eq%0d_predf", k), PredTakenF, 1);
            step();
        end
        check_val("eq_bcnt", BranchCnt, 3);
        check_val("eq_mcnt", MispredCnt, 1);

        // condition modes, no clock edge while branch is asserted
        for (int i = 0; i < 6; i++) begin
            drive_br(cvec[i].op, 32'h80, cvec[i].rd1, cvec[i].rd2, 1'b0, 1'b0);
            #1;
            check_val($sformatf("cmp%0d_pcsrc", i), PCSrcD, cvec[i].exp);
        end
        idle();
        #1;
        check_val("nobranch_pcsrc", PCSrcD, 0);
        step();

        // jump
        drive_br(3'd6, 32'h40, 32'h1234, 32'h0, 1'b0, 1'b0);
        #1;
        check_val("jreg_pcsrc", PCSrcD, 1);
        check_val("jreg_misp", MispredictD, 0);
        step();
        idle();
        #1;
        check_val("jreg_bht16", dut.bht_q[16], 3);
        check_val("jreg_bcnt", BranchCnt, 3);

        // stall for two cycles; PCF=0x40 in the prior cycle loads prediction 1
        step();
        PCF = 32'h80;
        for (int s = 0; s < 2; s++) begin
            drive_br(3'd1, 32'h80, 32'd1, 32'd2, 1'b1, 1'b0);
            #1;
            check_val($sformatf("stall%0d_misp", s), MispredictD, 0);
            check_val($sformatf("stall%0d_pred_d", s), dut.pred_taken_d_q, 1);
            step();
        end
        check_val("stall_bcnt", BranchCnt, 3);
        check_val("stall_bht32", dut.bht_q[32], 2'b01);
        drive_br(3'd1, 32'h80, 32'd1, 32'd2, 1'b0, 1'b0);
        #1;
        check_val("unstall_misp", MispredictD, 0);
        step();
        idle();
        PCF = 32'h40;
        #1;
        check_val("unstall_bcnt", BranchCnt, 4);
        check_val("unstall_bht32", dut.bht_q[32], 2);
        check_val("unstall_pred_d", dut.pred_taken_d_q, 0);
        step();
        check_val("preflush_pred_d", dut.pred_taken_d_q, 1);

        // flush (with stall) in the same cycle: flush wins
        drive_br(3'd1, 32'h80, 32'd1, 32'd2, 1'b1, 1'b1);
        #1;
        check_val("flush_misp", MispredictD, 0);
        step();
        idle();
        #1;
        check_val("flush_pred_d", dut.pred_taken_d_q, 0);
        check_val("flush_bht32", dut.bht_q[32], 2);
        check_val("flush_bcnt", BranchCnt, 4);
        check_val("flush_mcnt", MispredCnt, 1);

        // not-taken saturation at 0
        PCF = 32'hC;
        step();
        for (int k = 0; k < 2; k++) begin
            drive_br(3'd0, 32'hC, 32'd1, 32'd2, 1'b0, 1'b0);
            #1;
            check_val($sformatf("nt%0d_misp", k), MispredictD, 0);
            step();
        end
        idle();
        #1;
        check_val("nt_bht3", dut.bht_q[3], 0);
        check_val("nt_bcnt", BranchCnt, 6);

        // predicted taken, resolved not taken
        PCF = 32'h40;
        step();
        drive_br(3'd0, 32'h40, 32'd1, 32'd2, 1'b0, 1'b0);
        #1;
        check_val("pt_nt_pcsrc", PCSrcD, 0);
        check_val("pt_nt_misp", MispredictD, 1);
        step();
        idle();
        #1;
        check_val("pt_nt_bht16", dut.bht_q[16], 2);
        check_val("pt_nt_mcnt", MispredCnt, 2);
        check_val("pt_nt_bcnt", BranchCnt, 7);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check_val("arst_predf", PredTakenF, 0);
        check_val("arst_pcsrc", PCSrcD, 0);
        check_val("arst_misp", MispredictD, 0);
        check_val("arst_bcnt", BranchCnt, 0);
        check_val("arst_mcnt", MispredCnt, 0);
        check_val("arst_pred_d", dut.pred_taken_d_q, 0);
        for (int i = 0; i < 64; i++) begin
            check_val($sformatf("arst_bht%0d", i), dut.bht_q[i], 2'b01);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // first update after reset starts from weakly not-taken
        drive_br(3'd0, 32'h40, 32'd7, 32'd7, 1'b0, 1'b0);
        #1;
        check_val("post_rst_misp", MispredictD, 1);
        step();
        idle();
        #1;
        check_val("post_rst_bht16", dut.bht_q[16], 2);
        check_val("post_rst_predf", PredTakenF, 1);
        check_val("post_rst_bcnt", BranchCnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
BRANCH_UNIT -- requirements
Module: branch_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand width.
REQ-002 Parameter BHT_DEPTH, default 64, SHALL set the number of 2-bit predictor entries; it SHALL be a power of 2 and at least 4.
REQ-003 Parameter CNT_W, default 32, SHALL set the performance-counter width.
REQ-004 Port clk  in  1  is the single clock; the block SHALL use only its rising edge.
REQ-005 Port rst_n  in  1  is the asynchronous, active-low reset.
REQ-006 Port PCF  in  WIDTH  is the fetch PC; bits [log2(BHT_DEPTH)+1:2] SHALL form the lookup index.
REQ-007 Port PCD  in  WIDTH  is the decode PC; the same bit slice SHALL form the update index.
REQ-008 Port BranchD  in  1  flags a valid branch or jump in decode.
REQ-009 Port BrOpD  in  3  is the branch mode: EQ=0, NE=1, LTZ=2, GEZ=3, GTZ=4, LEZ=5, JREG=6, JVAL=7.
REQ-010 Ports RD1D and RD2D  in  WIDTH  are the decode operands, compared as two's complement.
REQ-011 Port StallD  in  1  holds the decode stage; Port FlushD  in  1  squashes the decode stage.
REQ-012 Port PredTakenF  out  1  is the combinational prediction for PCF.
REQ-013 Port PCSrcD  out  1  is the resolved taken decision.
REQ-014 Port MispredictD  out  1  flags a resolved conditional branch whose outcome differs from its prediction.
REQ-015 Ports BranchCnt and MispredCnt  out  CNT_W  are the performance counters.

Function
REQ-016 PredTakenF SHALL equal bit 1 of the BHT entry indexed by PCF.
REQ-017 PredTakenD SHALL be an internal register loaded with PredTakenF each cycle.
  - When StallD=1, PredTakenD SHALL hold its value.
  - When FlushD=1, PredTakenD SHALL clear to 0.
  - FlushD SHALL take priority over StallD.
REQ-018 The condition "taken" SHALL be evaluated per mode:
  - EQ: RD1D==RD2D
  - NE: RD1D!=RD2D
  - LTZ: RD1D<0
  - GEZ: RD1D>=0
  - GTZ: RD1D>0
  - LEZ: RD1D<=0
  - JREG, JVAL: always 1
REQ-019 PCSrcD SHALL equal BranchD AND taken, combinationally, with zero added latency.
REQ-020 MispredictD SHALL equal BranchD AND (BrOpD<=5) AND ~StallD AND ~FlushD AND (taken != PredTakenD).
REQ-021 A BHT update SHALL occur at the rising edge when BranchD=1, BrOpD<=5, StallD=0 and FlushD=0.
  - Taken: the entry at the PCD index SHALL increment, saturating at 3.
  - Not taken: the entry SHALL decrement, saturating at 0.
REQ-022 Jumps (JREG, JVAL) SHALL NOT update the BHT and SHALL NOT assert MispredictD.
REQ-023 When the same index is read via PCF and updated via PCD in one cycle, PredTakenF SHALL reflect the pre-update value (no bypass).
REQ-024 BranchCnt SHALL increment once per BHT update.
REQ-025 MispredCnt SHALL increment once per cycle in which MispredictD=1.
REQ-026 Both counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-027 While rst_n=0, all BHT entries SHALL be 2'b01 (weakly not-taken), and PredTakenD, BranchCnt and MispredCnt SHALL be 0.
REQ-028 Reset assertion mid-operation SHALL take effect immediately, independent of clk.
REQ-029 The first update after reset release SHALL start from 2'b01.

Structure
REQ-030 The BrOpD encodings and the BHT reset value SHALL reside in a shared package, branch_pkg.
REQ-031 The mode comparator SHALL be a combinational sub-module, branch_cmp, with ports BrOpD, RD1D, RD2D and taken.
REQ-032 The BHT, the prediction pipeline register and the counters SHALL reside in branch_unit.

Verification
REQ-033 Reset then PCF=0x40 -> PredTakenF=0; counters=0.
REQ-034 Three EQ branches at PCD=0x40 with RD1D=RD2D=5, no stall -> MispredictD=1 only on the first, BHT[16] goes 1->2->3->3, PredTakenF=1 for PCF=0x40, BranchCnt=3, MispredCnt=1.
REQ-035 LTZ with RD1D=0x80000000 -> PCSrcD=1; GTZ with RD1D=0 -> PCSrcD=0; LEZ with RD1D=0 -> PCSrcD=1.
REQ-036 JREG with BranchD=1 -> PCSrcD=1, MispredictD=0, BHT unchanged, BranchCnt unchanged.
REQ-037 NE branch with StallD=1 for 2 cycles, then StallD=0 -> PredTakenD held; single update and count only on the unstalled cycle; FlushD=1 in the same cycle -> no update, PredTakenD=0.
REQ-038 Assert rst_n=0 between clk edges after 5 updates -> all outputs and counters 0 immediately, and all entries read 2'b01.
